hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MUL_LATENCY, default 3, SHALL give the EX-stage occupancy of MUL in cycles; legal range 2..8.
REQ-002 Parameter REG_ADDR_W, default 5, SHALL give the register address width.
REQ-003 clk  in  1  SHALL be the single clock; everything is on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Rs1D, Rs2D  in  REG_ADDR_W  SHALL be the ID-stage source registers; UseRs1D, UseRs2D  in  1  SHALL mark each source as read.
REQ-006 Rs1E, Rs2E  in  REG_ADDR_W  SHALL be the EX-stage source registers.
REQ-007 RdE, RdM, RdW  in  REG_ADDR_W  SHALL be the destination registers per stage; RegWriteE, RegWriteM, RegWriteW  in  2  SHALL be the decoder RegWrite per stage, nonzero meaning write.
REQ-008 MemToRegE  in  1  SHALL mark a load (LoadWord/LoadHalfWord) in EX; MulStartE  in  1  SHALL mark a MUL in EX.
REQ-009 JumpD  in  1  SHALL mark a nonzero JMPSel in ID; BranchTakenE  in  1  SHALL mark a resolved taken BE/BGT in EX.
REQ-010 CntClr  in  1  SHALL synchronously clear the performance counters.
REQ-011 StallF, StallD, StallE  out  1  SHALL hold the PC, IF/ID and ID/EX registers; BubbleM  out  1  SHALL insert a NOP into EX/MEM.
REQ-012 FlushD, FlushE  out  1  SHALL squash IF/ID and ID/EX.
REQ-013 ForwardAE, ForwardBE  out  2  SHALL select the EX operand: 00 register file, 01 WB result, 10 MEM result.
REQ-014 MulBusy  out  1  SHALL be high while the MUL FSM is in MUL_BUSY.
REQ-015 StallCycles, FlushEvents  out  16  SHALL be the performance counters.

Function
REQ-016 A "match" SHALL require a nonzero address, a nonzero RegWrite and equal addresses; register 0 never matches.
REQ-017 ForwardAE SHALL be 10 on an Rs1E/MEM match, else 01 on an Rs1E/WB match, else 00, combinationally; ForwardBE SHALL apply the same rule to Rs2E.
REQ-018 Load-use SHALL be MemToRegE with RdE matching Rs1D (if UseRs1D) or Rs2D (if UseRs2D).
- On load-use: StallF=StallD=1 and FlushE=1 for that cycle only.
REQ-019 MUL FSM states SHALL be IDLE and MUL_BUSY, with a counter cnt of 3 bits.
REQ-020 In IDLE with MulStartE=1, the FSM SHALL go to MUL_BUSY with cnt<=MUL_LATENCY-2.
- In that same cycle: StallF=StallD=StallE=BubbleM=1.
REQ-021 In MUL_BUSY with cnt!=0: StallF=StallD=StallE=BubbleM=1 and cnt decrements.
- With cnt==0: no MUL stall and the FSM returns to IDLE.
- MulStartE SHALL be ignored throughout MUL_BUSY.
REQ-022 The MUL stall SHALL dominate load-use; FlushE SHALL NOT assert from load-use while StallE=1.
REQ-023 BranchTakenE SHALL force FlushD=FlushE=1 and clear StallF/StallD from load-use in the same cycle.
REQ-024 FlushD SHALL equal (JumpD and not StallD) or BranchTakenE.
REQ-025 StallCycles SHALL increment each cycle StallF=1, saturating at 0xFFFF.
REQ-026 FlushEvents SHALL increment each cycle FlushD or FlushE is 1, saturating at 0xFFFF.
REQ-027 CntClr SHALL zero both counters and override increment in the same cycle.

Reset
REQ-028 While rst=0: state IDLE, cnt=0, both counters 0.
- Outputs while rst=0: StallF/StallD/StallE/BubbleM=0, FlushD=FlushE=1, ForwardAE/BE=00, MulBusy=0.
REQ-029 Reset during MUL_BUSY SHALL abandon the MUL, with normal operation on the first cycle after rst=1.

Structure
REQ-030 Package hazard_pkg SHALL hold REG_ADDR_W, the forward-select encodings (FWD_REG, FWD_WB, FWD_MEM) and the MUL FSM state enum.
REQ-031 One sub-module, forward_select, SHALL be instantiated twice, once per EX operand.

Verification
REQ-032 RdM=3/RegWriteM=01, RdW=3/RegWriteW=01, Rs1E=3 -> ForwardAE=10; set RdM=0 -> ForwardAE=01.
REQ-033 MemToRegE=1, RdE=4, Rs2D=4, UseRs2D=1 -> StallF=StallD=FlushE=1 for exactly 1 cycle; UseRs2D=0 -> no stall.
REQ-034 MulStartE=1 held, MUL_LATENCY=3 -> StallE=BubbleM=1 for 2 cycles, then 0, FSM back in IDLE; MUL_LATENCY=2 -> 1 stall cycle.
REQ-035 Load-use plus BranchTakenE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0; JumpD=1 during a MUL stall -> FlushD=0.
REQ-036 rst=0 for one cycle mid-MUL_BUSY -> MulBusy=0 next cycle; StallCycles preset near 0xFFFF by stalling -> saturates at 0xFFFF; CntClr=1 -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, forward-select encodings and MUL FSM state
// type used by the hazard controller and its forwarding muxes.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [15:0] PERF_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == PERF_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Per-operand bypass select: MEM result beats WB result,
// register 0 and non-writing stages never match.
module forward_select
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic [1:0]        reg_write_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic [1:0]        reg_write_w,
  output logic [1:0]        fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = (rd_m != '0)
              && (reg_write_m != 2'b00)
              && (rd_m == rs);

  assign hit_w = (rd_w != '0)
              && (reg_write_w != 2'b00)
              && (rd_w == rs);

  always_comb begin
    fwd = FWD_REG;
    priority case (1'b1)
      hit_m:   fwd = FWD_MEM;
      hit_w:   fwd = FWD_WB;
      default: fwd = FWD_REG;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: forwarding, load-use interlock,
// multi-cycle MUL stall, branch/jump flushes, perf counters.
module hazard_controller #(
  parameter int MUL_LATENCY = 3,
  parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic                  UseRs1D,
  input  logic                  UseRs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            RegWriteE,
  input  logic [1:0]            RegWriteM,
  input  logic [1:0]            RegWriteW,
  input  logic                  MemToRegE,
  input  logic                  MulStartE,
  input  logic                  JumpD,
  input  logic                  BranchTakenE,
  input  logic                  CntClr,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  BubbleM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MulBusy,
  output logic [15:0]           StallCycles,
  output logic [15:0]           FlushEvents
);

  import hazard_pkg::*;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 2);

  mul_state_e state;
  mul_state_e state_d;
  logic [2:0] cnt;
  logic [2:0] cnt_d;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       hit_rs1d;
  logic       hit_rs2d;
  logic       load_use;
  logic       mul_stall;
  logic       lu_stall;
  logic       stall_fd;

  forward_select #(
    .ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_select #(
    .ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign hit_rs1d = UseRs1D
                 && (RdE != '0)
                 && (RegWriteE != 2'b00)
                 && (RdE == Rs1D);

  assign hit_rs2d = UseRs2D
                 && (RdE != '0)
                 && (RegWriteE != 2'b00)
                 && (RdE == Rs2D);

  assign load_use = MemToRegE
                 && (hit_rs1d || hit_rs2d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (MulStartE) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (cnt != 3'd0) begin
          cnt_d = cnt - 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MUL stall outranks load-use; a taken branch cancels
  // the load-use hold since the younger ops are squashed.
  always_comb begin
    mul_stall = ((state == IDLE) && MulStartE)
             || ((state == MUL_BUSY) && (cnt != 3'd0));
    lu_stall  = load_use && !BranchTakenE;
    stall_fd  = mul_stall || lu_stall;

    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    BubbleM   = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    MulBusy   = 1'b0;

    if (rst) begin
      StallF    = stall_fd;
      StallD    = stall_fd;
      StallE    = mul_stall;
      BubbleM   = mul_stall;
      FlushD    = (JumpD && !stall_fd)
               || BranchTakenE;
      FlushE    = BranchTakenE
               || (load_use && !mul_stall);
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      MulBusy   = (state == MUL_BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else if (CntClr) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallF) begin
        StallCycles <= sat_inc(StallCycles);
      end
      if (FlushD || FlushE) begin
        FlushEvents <= sat_inc(FlushEvents);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; a second
// instance with MUL_LATENCY=2 shares the same stimulus.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0] RdE, RdM, RdW;
  logic       UseRs1D, UseRs2D;
  logic [1:0] RegWriteE, RegWriteM, RegWriteW;
  logic       MemToRegE, MulStartE;
  logic       JumpD, BranchTakenE, CntClr;

  logic        StallF, StallD, StallE, BubbleM;
  logic        FlushD, FlushE, MulBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCycles, FlushEvents;

  logic        StallF2, StallD2, StallE2, BubbleM2;
  logic        FlushD2, FlushE2, MulBusy2;
  logic [1:0]  ForwardAE2, ForwardBE2;
  logic [15:0] StallCycles2, FlushEvents2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .MUL_LATENCY (3),
    .REG_ADDR_W  (5)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .UseRs1D      (UseRs1D),
    .UseRs2D      (UseRs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemToRegE    (MemToRegE),
    .MulStartE    (MulStartE),
    .JumpD        (JumpD),
    .BranchTakenE (BranchTakenE),
    .CntClr       (CntClr),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .BubbleM      (BubbleM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MulBusy      (MulBusy),
    .StallCycles  (StallCycles),
    .FlushEvents  (FlushEvents)
  );

  hazard_controller #(
    .MUL_LATENCY (2),
    .REG_ADDR_W  (5)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .UseRs1D      (UseRs1D),
    .UseRs2D      (UseRs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemToRegE    (MemToRegE),
    .MulStartE    (MulStartE),
    .JumpD        (JumpD),
    .BranchTakenE (BranchTakenE),
    .CntClr       (CntClr),
    .StallF       (StallF2),
    .StallD       (StallD2),
    .StallE       (StallE2),
    .BubbleM      (BubbleM2),
    .FlushD       (FlushD2),
    .FlushE       (FlushE2),
    .ForwardAE    (ForwardAE2),
    .ForwardBE    (ForwardBE2),
    .MulBusy      (MulBusy2),
    .StallCycles  (StallCycles2),
    .FlushEvents  (FlushEvents2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst          = 1'b1;
    Rs1D         = '0;
    Rs2D         = '0;
    Rs1E         = '0;
    Rs2E         = '0;
    RdE          = '0;
    RdM          = '0;
    RdW          = '0;
    UseRs1D      = 1'b0;
    UseRs2D      = 1'b0;
    RegWriteE    = '0;
    RegWriteM    = '0;
    RegWriteW    = '0;
    MemToRegE    = 1'b0;
    MulStartE    = 1'b0;
    JumpD        = 1'b0;
    BranchTakenE = 1'b0;
    CntClr       = 1'b0;
  endtask

  task automatic set_load_use();
    MemToRegE = 1'b1;
    RdE       = 5'd4;
    RegWriteE = 2'b01;
    Rs2D      = 5'd4;
    UseRs2D   = 1'b1;
  endtask

  initial begin
    quiet();
    rst       = 1'b0;
    RdM       = 5'd3;
    RegWriteM = 2'b01;
    Rs1E      = 5'd3;
    MulStartE = 1'b1;
    tick();
    #1;
    chk("rst_stallf",  32'(StallF),      32'd0);
    chk("rst_stalle",  32'(StallE),      32'd0);
    chk("rst_flushd",  32'(FlushD),      32'd1);
    chk("rst_flushe",  32'(FlushE),      32'd1);
    chk("rst_fwda",    32'(ForwardAE),   32'd0);
    chk("rst_mulbusy", 32'(MulBusy),     32'd0);
    chk("rst_stallc",  32'(StallCycles), 32'd0);
    chk("rst_flushev", 32'(FlushEvents), 32'd0);

    quiet();
    tick();
    RdM       = 5'd3;
    RegWriteM = 2'b01;
    RdW       = 5'd3;
    RegWriteW = 2'b01;
    Rs1E      = 5'd3;
    #1;
    chk("fwd_mem",     32'(ForwardAE), 32'd2);
    chk("fwd_b_none",  32'(ForwardBE), 32'd0);
    chk("fwd_flushd",  32'(FlushD),    32'd0);
    RdM = 5'd0;
    #1;
    chk("fwd_wb",      32'(ForwardAE), 32'd1);
    Rs2E = 5'd3;
    #1;
    chk("fwd_b_wb",    32'(ForwardBE), 32'd1);
    RegWriteW = 2'b00;
    #1;
    chk("fwd_wb_nowr", 32'(ForwardAE), 32'd0);
    RegWriteW = 2'b10;
    #1;
    chk("fwd_wb_rw10", 32'(ForwardAE), 32'd1);
    Rs1E      = 5'd0;
    RdW       = 5'd0;
    RegWriteM = 2'b01;
    #1;
    chk("fwd_r0",      32'(ForwardAE), 32'd0);

    quiet();
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    set_load_use();
    #1;
    chk("lu_stallf", 32'(StallF), 32'd1);
    chk("lu_stalld", 32'(StallD), 32'd1);
    chk("lu_flushe", 32'(FlushE), 32'd1);
    chk("lu_stalle", 32'(StallE), 32'd0);
    tick();
    MemToRegE = 1'b0;
    #1;
    chk("lu_one_cyc", 32'(StallF), 32'd0);
    MemToRegE = 1'b1;
    UseRs2D   = 1'b0;
    #1;
    chk("lu_nouse_st", 32'(StallF), 32'd0);
    chk("lu_nouse_fe", 32'(FlushE), 32'd0);
    UseRs2D   = 1'b1;
    RegWriteE = 2'b00;
    #1;
    chk("lu_norw",     32'(StallD), 32'd0);
    tick();
    chk("lu_stallcnt", 32'(StallCycles), 32'd1);
    chk("lu_flushcnt", 32'(FlushEvents), 32'd1);

    quiet();
    tick();
    MulStartE = 1'b1;
    #1;
    chk("mul0_stalle",  32'(StallE),  32'd1);
    chk("mul0_bubble",  32'(BubbleM), 32'd1);
    chk("mul0_stallf",  32'(StallF),  32'd1);
    chk("mul0_busy",    32'(MulBusy), 32'd0);
    chk("mul0_l2",      32'(StallE2), 32'd1);
    tick();
    set_load_use();
    JumpD = 1'b1;
    #1;
    chk("mul1_stalle",  32'(StallE),  32'd1);
    chk("mul1_busy",    32'(MulBusy), 32'd1);
    chk("mul1_lu_fe",   32'(FlushE),  32'd0);
    chk("mul1_lu_sf",   32'(StallF),  32'd1);
    chk("mul1_jmp_fd",  32'(FlushD),  32'd0);
    chk("mul1_l2",      32'(StallE2), 32'd0);
    tick();
    MemToRegE = 1'b0;
    JumpD     = 1'b0;
    #1;
    chk("mul2_stalle",  32'(StallE),  32'd0);
    chk("mul2_bubble",  32'(BubbleM), 32'd0);
    chk("mul2_busy",    32'(MulBusy), 32'd1);
    tick();
    MulStartE = 1'b0;
    #1;
    chk("mul3_idle",    32'(MulBusy), 32'd0);
    chk("mul3_stalle",  32'(StallE),  32'd0);
    repeat (3) tick();

    quiet();
    set_load_use();
    BranchTakenE = 1'b1;
    #1;
    chk("br_flushd", 32'(FlushD), 32'd1);
    chk("br_flushe", 32'(FlushE), 32'd1);
    chk("br_stallf", 32'(StallF), 32'd0);
    chk("br_stalld", 32'(StallD), 32'd0);
    quiet();
    JumpD = 1'b1;
    #1;
    chk("jmp_flushd", 32'(FlushD), 32'd1);
    chk("jmp_flushe", 32'(FlushE), 32'd0);

    quiet();
    tick();
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    #1;
    chk("rmul_busy", 32'(MulBusy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rmul_in_busy", 32'(MulBusy), 32'd0);
    chk("rmul_in_st",   32'(StallE),  32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rmul_after",   32'(MulBusy),     32'd0);
    chk("rmul_after_s", 32'(StallE),      32'd0);
    chk("rmul_cnt0",    32'(StallCycles), 32'd0);

    set_load_use();
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    #1;
    chk("sat_clr_ovr", 32'(StallCycles), 32'd0);
    repeat (65534) tick();
    chk("sat_fffe",    32'(StallCycles), 32'hFFFE);
    tick();
    chk("sat_ffff",    32'(StallCycles), 32'hFFFF);
    tick();
    chk("sat_hold",    32'(StallCycles), 32'hFFFF);
    chk("sat_flush",   32'(FlushEvents), 32'hFFFF);
    CntClr = 1'b1;
    tick();
    chk("clr_stallc",  32'(StallCycles), 32'd0);
    chk("clr_flushev", 32'(FlushEvents), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
